csel_adder_pipe: RTL and testbench
==================================

# csel_adder_pipe

- Parametrised, two-stage pipelined carry-select adder/subtractor with a valid/ready handshake on both sides.
- Each operand is split into equal blocks; every block precomputes its sum for both carry-in hypotheses in stage 1, and stage 2 resolves the block carry chain by selection.
- It is the datapath adder for wider arithmetic units, where a registered, stallable, full-throughput add/sub of configurable width is needed.

## Interface

Parameters:
- WIDTH, 32: operand and sum width in bits; must be a multiple of BLK_W.
- BLK_W, 8: carry-select block width in bits; NUM_BLK = WIDTH/BLK_W, which must be ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts the input this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when op = OP_SUB.
- op  in  1  OP_ADD (0) or OP_SUB (1).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB; for SUB, 1 means no borrow.
- ovf  out  1  signed overflow.

## Operation

Operand preparation, combinational at the input:
- OP_ADD: bb = b, c0 = cin.
- OP_SUB: bb = ~b, c0 = 1.

Stage 1, registered on input accept:
- For every block k, compute s0_k, co0_k = a_k + bb_k + 0 and s1_k, co1_k = a_k + bb_k + 1. Each sum is BLK_W bits, each carry 1 bit.
- Block 0 is computed directly with c0; only its one sum and carry are stored.
- Also register the operand MSBs a[W-1] and bb[W-1] for the overflow computation.

Stage 2, registered on stage-1 advance:
- Carry chain: c_1 = co_0 (block 0 carry-out); c_{k+1} = c_k ? co1_k : co0_k.
- Every sum bit of block k is selected by c_k: sum_k = c_k ? s1_k : s0_k. All BLK_W bits use the same select; no bit may take the c=1 result unconditionally.
- cout = c_NUM_BLK.
- ovf = (a_msb == bb_msb) && (sum[W-1] != a_msb).

Arithmetic:
- The result is modulo 2^WIDTH.
- SUB result equals a − b mod 2^WIDTH.

Handshake:
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Internal valid bits: v1 for stage 1, out_valid for stage 2.
- adv2 = v1 && (!out_valid || out_ready).
- in_ready = !v1 || adv2. This is combinational from out_ready, with no path from in_valid.
- Stage-1 registers load only on an input transfer; v1 follows the input transfer or clears on adv2.
- Output registers load only on adv2. out_valid is set on adv2 and cleared on an output transfer with no adv2.
- With out_valid held and out_ready = 0: sum, cout and ovf hold stable, and the block accepts at most one further input (into stage 1).
- Simultaneous output transfer, stage advance and input transfer in one cycle is legal; the block sustains one result per cycle.

Reset:
- rst_n low asynchronously clears v1 and out_valid, and zeroes sum, cout, ovf and all stage-1 registers.
- In-flight operations are discarded with no partial output.
- in_ready is 1 from the first cycle after reset release.

## Timing

- Latency: 2 cycles from the input transfer edge to out_valid high, when not stalled.
- Throughput: 1 op/cycle with out_ready held high.
- Critical path: in stage 1, one BLK_W ripple; in stage 2, a NUM_BLK-long mux chain plus the sum mux.
- Capacity: at most 2 operations resident.
- Outputs come directly from registers; none are combinational from a, b or op.

## Structure

- Package csel_pkg:
  - op encoding constants OP_ADD and OP_SUB, as a typedef op_t.
  - Default WIDTH and BLK_W.
  - Function num_blk(width, blk_w).
  - Elaboration check that WIDTH % BLK_W == 0.
- Sub-module csel_block (combinational):
  - Parameter BLK_W; inputs a, b.
  - Outputs s0, co0, s1, co1.
  - The top instantiates it NUM_BLK−1 times via generate; block 0 uses a plain adder with c0.
- Top module csel_adder_pipe holds the handshake control, both register stages and the select chain.

## Test plan

- WIDTH=32, BLK_W=8, ADD, a=0x0000_00FF, b=0x0000_0001, cin=0 -> sum=0x0000_0100, cout=0, ovf=0, out_valid 2 cycles after accept. Checks carry select across a block boundary.
- ADD, a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1. Checks full chain propagation. ADD, a=0x1234_5678, b=0x1111_1111, cin=0 -> sum=0x2345_6789; no upper-block bit may reflect the c=1 result.
- SUB, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0. SUB, a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Back-to-back stream of 100 random ops with out_ready=1 -> one result per cycle in order, matching the reference model. Then hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, sum holds stable, no loss or duplication on release.
- Assert rst_n low mid-stream with both stages valid -> out_valid=0 and sum=0 immediately (asynchronously). After release, the first new op is returned correctly with no stale result.
- WIDTH=16, BLK_W=4 and WIDTH=64, BLK_W=16 -> random add/sub, including cin and signed-overflow corners, matching the model.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
// Holds the op encoding, the default geometry and the geometry helpers.
package csel_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  localparam int CSEL_WIDTH = 32;
  localparam int CSEL_BLK_W = 8;

  function automatic int num_blk(input int width, input int blk_w);
    return width / blk_w;
  endfunction

  // A legal geometry needs whole blocks and at least two of them.
  function automatic bit cfg_ok(input int width, input int blk_w);
    return (blk_w > 0) && ((width % blk_w) == 0) && ((width / blk_w) >= 2);
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: the block sum and carry-out for both carry-in hypotheses.
module csel_block #(
  parameter int BLK_W = 8
) (
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  output logic [BLK_W-1:0] s0,
  output logic             co0,
  output logic [BLK_W-1:0] s1,
  output logic             co1
);

  assign {co0, s0} = {1'b0, a} + {1'b0, b};
  assign {co1, s1} = {1'b0, a} + {1'b0, b} + {{BLK_W{1'b0}}, 1'b1};

endmodule

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 precomputes both carry hypotheses per block; stage 2 resolves the block carry chain.
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH,
  parameter int BLK_W = CSEL_BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NUM_BLK = num_blk(WIDTH, BLK_W);

  if (!cfg_ok(WIDTH, BLK_W)) begin : g_cfg_err
    $error("csel_adder_pipe: WIDTH must be a multiple of BLK_W with at least two blocks");
  end

  logic [WIDTH-1:0]     bb_s;
  logic                 c0_s;
  logic [BLK_W-1:0]     lo_sum_s;
  logic                 lo_co_s;
  logic [WIDTH-1:BLK_W] s0_s;
  logic [WIDTH-1:BLK_W] s1_s;
  logic [NUM_BLK-1:1]   co0_s;
  logic [NUM_BLK-1:1]   co1_s;

  logic                 v1_r;
  logic [BLK_W-1:0]     lo_sum_r;
  logic                 lo_co_r;
  logic [WIDTH-1:BLK_W] s0_r;
  logic [WIDTH-1:BLK_W] s1_r;
  logic [NUM_BLK-1:1]   co0_r;
  logic [NUM_BLK-1:1]   co1_r;
  logic                 a_msb_r;
  logic                 bb_msb_r;

  logic [WIDTH-1:0]     sel_sum_s;
  logic                 sel_cout_s;
  logic                 ovf_s;
  logic                 adv2_s;
  logic                 in_xfer_s;
  logic                 out_xfer_s;

  // Operand preparation: subtraction is a + ~b + 1
  always_comb begin
    if (op_t'(op) == OP_SUB) begin
      bb_s = ~b;
      c0_s = 1'b1;
    end else begin
      bb_s = b;
      c0_s = cin;
    end
  end

  assign {lo_co_s, lo_sum_s} = {1'b0, a[BLK_W-1:0]} + {1'b0, bb_s[BLK_W-1:0]}
                             + {{BLK_W{1'b0}}, c0_s};

  for (genvar k = 1; k < NUM_BLK; k++) begin : g_blk
    csel_block #(.BLK_W(BLK_W)) u_blk (
      .a   (a[k*BLK_W +: BLK_W]),
      .b   (bb_s[k*BLK_W +: BLK_W]),
      .s0  (s0_s[k*BLK_W +: BLK_W]),
      .co0 (co0_s[k]),
      .s1  (s1_s[k*BLK_W +: BLK_W]),
      .co1 (co1_s[k])
    );
  end

  assign adv2_s     = v1_r && (!out_valid || out_ready);
  assign in_ready   = !v1_r || adv2_s;
  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = out_valid && out_ready;

  // Stage 1: capture per-block hypotheses on an input transfer; v1 tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r     <= 1'b0;
      lo_sum_r <= '0;
      lo_co_r  <= 1'b0;
      s0_r     <= '0;
      s1_r     <= '0;
      co0_r    <= '0;
      co1_r    <= '0;
      a_msb_r  <= 1'b0;
      bb_msb_r <= 1'b0;
    end else begin
      if (in_xfer_s) begin
        v1_r     <= 1'b1;
        lo_sum_r <= lo_sum_s;
        lo_co_r  <= lo_co_s;
        s0_r     <= s0_s;
        s1_r     <= s1_s;
        co0_r    <= co0_s;
        co1_r    <= co1_s;
        a_msb_r  <= a[WIDTH-1];
        bb_msb_r <= bb_s[WIDTH-1];
      end else if (adv2_s) begin
        v1_r <= 1'b0;
      end
    end
  end

  // Stage 2 select chain: each block's whole sum follows the carry entering it
  always_comb begin
    logic carry;
    sel_sum_s              = '0;
    sel_sum_s[BLK_W-1:0]   = lo_sum_r;
    carry                  = lo_co_r;
    for (int k = 1; k < NUM_BLK; k++) begin
      if (carry) begin
        sel_sum_s[k*BLK_W +: BLK_W] = s1_r[k*BLK_W +: BLK_W];
        carry                       = co1_r[k];
      end else begin
        sel_sum_s[k*BLK_W +: BLK_W] = s0_r[k*BLK_W +: BLK_W];
        carry                       = co0_r[k];
      end
    end
    sel_cout_s = carry;
  end

  assign ovf_s = (a_msb_r == bb_msb_r) && (sel_sum_s[WIDTH-1] != a_msb_r);

  // Stage 2 output registers: load on advance, hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (adv2_s) begin
        out_valid <= 1'b1;
        sum       <= sel_sum_s;
        cout      <= sel_cout_s;
        ovf       <= ovf_s;
      end else if (out_xfer_s) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe at 32/8, 16/4 and 64/16 geometries.
// Expected results are queued on input transfer and popped on output transfer.
module tb_csel_adder_pipe;
  import csel_pkg::*;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid_t;
  logic        out_ready_t;
  logic        cin_t;
  logic        op_v;
  logic [63:0] a_t;
  logic [63:0] b_t;
  int          sel;
  int          cur_w;

  logic        iv32, ir32, ov32, c32, f32;
  logic [31:0] s32;
  logic        iv16, ir16, ov16, c16, f16;
  logic [15:0] s16;
  logic        iv64, ir64, ov64, c64, f64;
  logic [63:0] s64;

  logic        obs_ir, obs_ov, obs_cout, obs_ovf;
  logic [63:0] obs_sum;

  assign iv32 = in_valid_t && (sel == 0);
  assign iv16 = in_valid_t && (sel == 1);
  assign iv64 = in_valid_t && (sel == 2);

  csel_adder_pipe #(.WIDTH(32), .BLK_W(8)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .a(a_t[31:0]), .b(b_t[31:0]), .cin(cin_t), .op(op_v),
    .out_valid(ov32), .out_ready(out_ready_t), .sum(s32), .cout(c32), .ovf(f32));

  csel_adder_pipe #(.WIDTH(16), .BLK_W(4)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a_t[15:0]), .b(b_t[15:0]), .cin(cin_t), .op(op_v),
    .out_valid(ov16), .out_ready(out_ready_t), .sum(s16), .cout(c16), .ovf(f16));

  csel_adder_pipe #(.WIDTH(64), .BLK_W(16)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
    .a(a_t), .b(b_t), .cin(cin_t), .op(op_v),
    .out_valid(ov64), .out_ready(out_ready_t), .sum(s64), .cout(c64), .ovf(f64));

  always_comb begin
    case (sel)
      0: begin
        obs_ir = ir32; obs_ov = ov32; obs_sum = {32'd0, s32}; obs_cout = c32; obs_ovf = f32;
      end
      1: begin
        obs_ir = ir16; obs_ov = ov16; obs_sum = {48'd0, s16}; obs_cout = c16; obs_ovf = f16;
      end
      default: begin
        obs_ir = ir64; obs_ov = ov64; obs_sum = s64; obs_cout = c64; obs_ovf = f64;
      end
    endcase
  end

  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_cyc = 0;
  exp_t q[$];
  exp_t cur_exp;

  // Flat reference: ADD is a full add, SUB is a plain difference with borrow/sign rules.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic op, input int w);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] mask, am, bm;
    logic        sa, sb, sr;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am = a & mask;
    bm = b & mask;
    sa = am[w-1];
    sb = bm[w-1];
    if (op) begin
      e.sum  = (am - bm) & mask;
      e.cout = (am >= bm);
      sr     = e.sum[w-1];
      e.ovf  = (sa != sb) && (sr != sa);
    end else begin
      full   = {1'b0, am} + {1'b0, bm} + {64'd0, cin};
      e.sum  = full[63:0] & mask;
      e.cout = full[w];
      sr     = e.sum[w-1];
      e.ovf  = (sa == sb) && (sr != sa);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: settle, score the transfers happening at the next edge, then step past it.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = in_valid_t && obs_ir;
    if (obs_ov && out_ready_t) begin
      check("result_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sum", obs_sum, e.sum);
        check("cout", 64'(obs_cout), 64'(e.cout));
        check("ovf", 64'(obs_ovf), 64'(e.ovf));
      end
    end
    if (acc) begin
      q.push_back(cur_exp);
      n_acc++;
    end
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic op, input exp_t e);
    bit acc;
    acc = 1'b0;
    a_t = a; b_t = b; cin_t = cin; op_v = op;
    cur_exp = e;
    in_valid_t = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic issue_m(input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic op);
    issue(a, b, cin, op, model(a, b, cin, op, cur_w));
  endtask

  task automatic drain();
    bit acc;
    in_valid_t  = 1'b0;
    out_ready_t = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick(acc);
    tick(acc);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic width_run(input int s, input int w);
    logic [63:0] mask, maxp, minn;
    sel   = s;
    cur_w = w;
    mask  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    maxp  = mask >> 1;
    minn  = maxp + 64'd1;
    issue_m(maxp, 64'd1, 1'b0, OP_ADD);
    issue_m(minn, minn, 1'b0, OP_ADD);
    issue_m(mask, 64'd0, 1'b1, OP_ADD);
    issue_m(mask, mask, 1'b1, OP_ADD);
    issue_m(minn, 64'd1, 1'b1, OP_SUB);
    issue_m(64'd0, minn, 1'b0, OP_SUB);
    issue_m(maxp, maxp, 1'b0, OP_SUB);
    for (int i = 0; i < 40; i++)
      issue_m({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          acc0, cyc0;
    logic [63:0] held;
    exp_t        e;

    rst_n = 1'b0; in_valid_t = 1'b0; out_ready_t = 1'b1;
    cin_t = 1'b0; op_v = 1'b0; a_t = 64'd0; b_t = 64'd0;
    sel = 0; cur_w = 32;
    #12;
    check("rst_out_valid", 64'(obs_ov), 64'd0);
    check("rst_sum", obs_sum, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(obs_ir), 64'd1);

    // Latency and block-boundary carry select
    e = '{sum: 64'h0000_0100, cout: 1'b0, ovf: 1'b0};
    issue(64'h0000_00FF, 64'h0000_0001, 1'b0, OP_ADD, e);
    in_valid_t = 1'b0;
    check("latency_edge1", 64'(obs_ov), 64'd0);
    tick(acc);
    check("latency_edge2", 64'(obs_ov), 64'd1);
    drain();

    // Directed carry chain and subtract corners
    e = '{sum: 64'h0000_0000, cout: 1'b1, ovf: 1'b0};
    issue(64'hFFFF_FFFF, 64'h0, 1'b1, OP_ADD, e);
    e = '{sum: 64'h2345_6789, cout: 1'b0, ovf: 1'b0};
    issue(64'h1234_5678, 64'h1111_1111, 1'b0, OP_ADD, e);
    e = '{sum: 64'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0};
    issue(64'd5, 64'd7, 1'b0, OP_SUB, e);
    e = '{sum: 64'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1};
    issue(64'h8000_0000, 64'd1, 1'b1, OP_SUB, e);
    drain();

    // Full-throughput random stream
    cyc0 = n_cyc;
    for (int i = 0; i < 100; i++)
      issue_m({32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    check("stream_cycles", 64'(n_cyc - cyc0), 64'd100);
    drain();

    // Output stall: two accepts, then backpressure with stable outputs
    out_ready_t = 1'b0;
    acc0 = n_acc;
    in_valid_t = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_t = {32'd0, $urandom}; b_t = {32'd0, $urandom};
      cin_t = 1'($urandom_range(0, 1)); op_v = 1'($urandom_range(0, 1));
      cur_exp = model(a_t, b_t, cin_t, op_v, cur_w);
      tick(acc);
    end
    check("stall_accepts", 64'(n_acc - acc0), 64'd2);
    check("stall_in_ready", 64'(obs_ir), 64'd0);
    check("stall_out_valid", 64'(obs_ov), 64'd1);
    held = obs_sum;
    tick(acc);
    tick(acc);
    check("stall_sum_hold", obs_sum, held);
    check("stall_no_accept", 64'(n_acc - acc0), 64'd2);
    drain();

    // Asynchronous reset with both stages occupied
    out_ready_t = 1'b0;
    in_valid_t  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_t = {32'd0, $urandom}; b_t = {32'd0, $urandom} | 64'd1;
      cin_t = 1'b1; op_v = OP_ADD;
      cur_exp = model(a_t, b_t, cin_t, op_v, cur_w);
      tick(acc);
    end
    in_valid_t = 1'b0;
    check("pre_reset_full", 64'(obs_ov && !obs_ir), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(obs_ov), 64'd0);
    check("async_rst_sum", obs_sum, 64'd0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready_t = 1'b1;
    check("post_reset_ready", 64'(obs_ir), 64'd1);
    tick(acc);
    check("post_reset_no_stale", 64'(obs_ov), 64'd0);
    issue_m(64'h0000_0000_DEAD_BEEF, 64'h0000_0000_1234_4321, 1'b0, OP_SUB);
    drain();

    width_run(1, 16);
    width_run(2, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
